// File: rtl/fft_chan_sched_pkg.sv
// Shared constants, state encoding and helpers for the FFT channel scheduler.
package fft_chan_sched_pkg;

   localparam int NFFT_DEF   = 256;
   localparam int ADDR_W_DEF = 8;
   localparam int TO_CYC_DEF = 4095;
   localparam int TO_W_DEF   = 12;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_WAIT_DV = 3'd3,
      ST_UNLOAD  = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // Channel index (0 = ADC1, 1 = ADC2) to its ch_done bit.
   function automatic logic [1:0] ch_onehot(input logic ch);
      ch_onehot = {ch, ~ch};
   endfunction

endpackage

// File: rtl/fft_chan_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the channel not served last wins.
module fft_chan_sched_rr_arb2 (
   input  logic [1:0] i_eligible,
   input  logic       i_last_ch,
   output logic       o_gnt,
   output logic       o_gnt_ch
);

   assign o_gnt    = |i_eligible;
   assign o_gnt_ch = (&i_eligible) ? ~i_last_ch : i_eligible[1];

endmodule

// File: rtl/fft_chan_sched.sv
// Time-shares one FFT core between ADC1 and ADC2: arbitrate, start, load, collect, signal done.
module fft_chan_sched
   import fft_chan_sched_pkg::*;
#(
   parameter int NFFT   = NFFT_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int TO_CYC = TO_CYC_DEF,
   parameter int TO_W   = TO_W_DEF
) (
   input  logic              clk_FFT,
   input  logic              rst_n,
   input  logic [1:0]        frame_req,
   input  logic [1:0]        rd_busy,
   input  logic              dv_FFT,
   output logic              start_FFT,
   output logic              En_FFT1,
   output logic              xn_sel,
   output logic              xn_rd_en,
   output logic [ADDR_W-1:0] xn_rd_addr,
   output logic [1:0]        ch_done,
   output logic              busy,
   output logic              to_err
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NFFT - 1);
   localparam logic [ADDR_W:0]   UCNT_LAST = (ADDR_W+1)'(NFFT - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYC - 1);

   state_t              r_state, w_state_next;
   logic                r_cur_ch, r_last_ch, r_start, r_en_fft1, r_xn_sel, r_rd_en;
   logic                r_busy, r_to_err;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_ucnt;
   logic [TO_W-1:0]     r_to_cnt;
   logic [1:0]          r_ch_done;

   logic                w_gnt, w_gnt_ch, w_err_set;
   logic [1:0]          w_eligible;
   logic                w_cur_ch_next, w_last_ch_next, w_en_fft1_next, w_xn_sel_next;
   logic [ADDR_W-1:0]   w_addr_next;
   logic [ADDR_W:0]     w_ucnt_next;
   logic [TO_W-1:0]     w_to_next;
   logic [1:0]          w_ch_done_next;

   assign w_eligible = frame_req & ~rd_busy;

   fft_chan_sched_rr_arb2 u_arb (
      .i_eligible (w_eligible),
      .i_last_ch  (r_last_ch),
      .o_gnt      (w_gnt),
      .o_gnt_ch   (w_gnt_ch)
   );

   always_ff @(posedge clk_FFT or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Requests and dv_FFT only matter in the states that look at them.
   always_comb begin
      w_state_next = r_state;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE:    if (w_gnt) w_state_next = ST_START;
         ST_START:   w_state_next = ST_LOAD;
         ST_LOAD:    if (r_addr == ADDR_LAST) w_state_next = ST_WAIT_DV;
         ST_WAIT_DV: begin
            if (dv_FFT) begin
               w_state_next = ST_UNLOAD;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_next = ST_DONE;
               w_err_set    = 1'b1;
            end
         end
         ST_UNLOAD: begin
            if (!dv_FFT) begin
               w_state_next = ST_DONE;
               w_err_set    = 1'b1;
            end else if (r_ucnt == UCNT_LAST) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE:    w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cur_ch_next  = r_cur_ch;
      w_last_ch_next = r_last_ch;
      w_en_fft1_next = r_en_fft1;
      w_xn_sel_next  = r_xn_sel;
      w_addr_next    = '0;
      w_ucnt_next    = r_ucnt;
      w_to_next      = r_to_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt) begin
               w_cur_ch_next  = w_gnt_ch;
               w_en_fft1_next = ~w_gnt_ch;
               w_xn_sel_next  = w_gnt_ch;
            end
         end
         ST_START: begin
            w_ucnt_next = '0;
            w_to_next   = '0;
         end
         ST_LOAD:    if (w_state_next == ST_LOAD) w_addr_next = r_addr + 1'b1;
         ST_WAIT_DV: begin
            w_to_next = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 1'b1;
            if (dv_FFT) w_ucnt_next = (ADDR_W+1)'(1);
         end
         ST_UNLOAD:  if (dv_FFT) w_ucnt_next = r_ucnt + 1'b1;
         ST_DONE:    w_last_ch_next = r_cur_ch;
         default:    ;
      endcase
      w_ch_done_next = (w_state_next == ST_DONE && !w_err_set) ? ch_onehot(r_cur_ch) : 2'b00;
   end

   always_ff @(posedge clk_FFT or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_ch  <= 1'b0;
         r_last_ch <= 1'b1;
         r_start   <= 1'b0;
         r_en_fft1 <= 1'b1;
         r_xn_sel  <= 1'b0;
         r_rd_en   <= 1'b0;
         r_addr    <= '0;
         r_ucnt    <= '0;
         r_to_cnt  <= '0;
         r_ch_done <= 2'b00;
         r_busy    <= 1'b0;
         r_to_err  <= 1'b0;
      end else begin
         r_cur_ch  <= w_cur_ch_next;
         r_last_ch <= w_last_ch_next;
         r_start   <= (w_state_next == ST_START);
         r_en_fft1 <= w_en_fft1_next;
         r_xn_sel  <= w_xn_sel_next;
         r_rd_en   <= (w_state_next == ST_LOAD);
         r_addr    <= w_addr_next;
         r_ucnt    <= w_ucnt_next;
         r_to_cnt  <= w_to_next;
         r_ch_done <= w_ch_done_next;
         r_busy    <= (w_state_next != ST_IDLE);
         r_to_err  <= r_to_err | w_err_set;
      end
   end

   assign start_FFT  = r_start;
   assign En_FFT1    = r_en_fft1;
   assign xn_sel     = r_xn_sel;
   assign xn_rd_en   = r_rd_en;
   assign xn_rd_addr = r_addr;
   assign ch_done    = r_ch_done;
   assign busy       = r_busy;
   assign to_err     = r_to_err;

endmodule

// File: tb/tb_fft_chan_sched.sv
// Directed bench for fft_chan_sched: arbitration, load sequence, unload, timeout and reset.
module tb_fft_chan_sched;

   localparam int NFFT   = 256;
   localparam int TO_CYC = 4095;

   logic       clk_FFT = 1'b0;
   logic       rst_n;
   logic [1:0] frame_req;
   logic [1:0] rd_busy;
   logic       dv_FFT;
   logic       start_FFT, En_FFT1, xn_sel, xn_rd_en, busy, to_err;
   logic [7:0] xn_rd_addr;
   logic [1:0] ch_done;

   int n_vec = 0;
   int n_err = 0;

   fft_chan_sched dut (
      .clk_FFT    (clk_FFT),
      .rst_n      (rst_n),
      .frame_req  (frame_req),
      .rd_busy    (rd_busy),
      .dv_FFT     (dv_FFT),
      .start_FFT  (start_FFT),
      .En_FFT1    (En_FFT1),
      .xn_sel     (xn_sel),
      .xn_rd_en   (xn_rd_en),
      .xn_rd_addr (xn_rd_addr),
      .ch_done    (ch_done),
      .busy       (busy),
      .to_err     (to_err)
   );

   always #5 clk_FFT = ~clk_FFT;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk_FFT);
      #1;
   endtask

   task automatic check_reset_vals(input string ctx);
      check_val({ctx, "_start"},   32'(start_FFT),  32'd0);
      check_val({ctx, "_en_fft1"}, 32'(En_FFT1),    32'd1);
      check_val({ctx, "_xn_sel"},  32'(xn_sel),     32'd0);
      check_val({ctx, "_rd_en"},   32'(xn_rd_en),   32'd0);
      check_val({ctx, "_addr"},    32'(xn_rd_addr), 32'd0);
      check_val({ctx, "_done"},    32'(ch_done),    32'd0);
      check_val({ctx, "_busy"},    32'(busy),       32'd0);
      check_val({ctx, "_to_err"},  32'(to_err),     32'd0);
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      frame_req = 2'b00;
      rd_busy   = 2'b00;
      dv_FFT    = 1'b0;
      step();
      step();
      check_reset_vals("rst");
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_start(input string ctx);
      int n = 0;
      while (!start_FFT && n < 20) begin
         step();
         n++;
      end
      check_val({ctx, "_start_seen"}, 32'(start_FFT), 32'd1);
   endtask

   // One full frame: grant/start, NFFT-sample load, then unload or timeout, back to IDLE.
   task automatic do_frame(input string ctx, input logic ch, input int dv_delay, input int dv_len,
                           input int exp_done, input logic exp_err, input logic [1:0] drop);
      int         bad      = 0;
      int         done_cnt = 0;
      logic [1:0] done_val = 2'b00;
      logic       idle_seen = 1'b0;
      logic       exp_en;
      logic [1:0] exp_oh;
      exp_en = ~ch;
      exp_oh = ch ? 2'b10 : 2'b01;
      wait_start(ctx);
      check_val({ctx, "_en_fft1"}, 32'(En_FFT1), 32'(exp_en));
      check_val({ctx, "_xn_sel"},  32'(xn_sel),  32'(ch));
      step();
      for (int i = 0; i < NFFT; i++) begin
         if (xn_rd_en !== 1'b1 || 32'(xn_rd_addr) != i || start_FFT !== 1'b0 ||
             En_FFT1 !== exp_en || xn_sel !== ch)
            bad++;
         step();
      end
      check_val({ctx, "_load_bad"},  32'(bad),        32'd0);
      check_val({ctx, "_load_end"},  32'(xn_rd_en),   32'd0);
      check_val({ctx, "_addr_zero"}, 32'(xn_rd_addr), 32'd0);
      check_val({ctx, "_busy_wait"}, 32'(busy),       32'd1);
      if (dv_len == 0) begin
         repeat (TO_CYC - 1) step();
         check_val({ctx, "_to_early"}, 32'(to_err), 32'd0);
         step();
         check_val({ctx, "_to_hit"}, 32'(to_err), 32'd1);
      end else begin
         repeat (dv_delay) step();
         dv_FFT = 1'b1;
         repeat (dv_len) step();
         dv_FFT = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         if (ch_done != 2'b00) begin
            done_cnt++;
            done_val = ch_done;
         end
         if (!busy) begin
            idle_seen = 1'b1;
            break;
         end
         step();
      end
      check_val({ctx, "_idle"},     32'(idle_seen), 32'd1);
      check_val({ctx, "_done_cnt"}, 32'(done_cnt),  32'(exp_done));
      if (exp_done != 0) check_val({ctx, "_done_ch"}, 32'(done_val), 32'(exp_oh));
      check_val({ctx, "_to_err"}, 32'(to_err), 32'(exp_err));
      frame_req = frame_req & ~drop;
      $display("frame %s: ch=%0d En_FFT1=%0b done_pulses=%0d ch_done=%b to_err=%0b",
               ctx, ch, exp_en, done_cnt, done_val, to_err);
   endtask

   initial begin
      rst_n     = 1'b0;
      frame_req = 2'b00;
      rd_busy   = 2'b00;
      dv_FFT    = 1'b0;
      apply_reset();

      // Single ADC1 frame, dv_FFT 40 cycles after load.
      frame_req = 2'b01;
      do_frame("t1", 1'b0, 40, NFFT, 1, 1'b0, 2'b01);

      // Both requesting continuously: ADC1, ADC2, ADC1.
      apply_reset();
      frame_req = 2'b11;
      do_frame("t2a", 1'b0, 4, NFFT, 1, 1'b0, 2'b00);
      do_frame("t2b", 1'b1, 4, NFFT, 1, 1'b0, 2'b00);
      do_frame("t2c", 1'b0, 4, NFFT, 1, 1'b0, 2'b11);

      // Blocked by rd_busy; stray dv_FFT in IDLE is ignored.
      frame_req = 2'b01;
      rd_busy   = 2'b01;
      dv_FFT    = 1'b1;
      repeat (5) step();
      check_val("t3_blocked_busy",  32'(busy),      32'd0);
      check_val("t3_blocked_start", 32'(start_FFT), 32'd0);
      check_val("t3_dv_idle_err",   32'(to_err),    32'd0);
      dv_FFT  = 1'b0;
      rd_busy = 2'b00;
      step();
      check_val("t3_go_start", 32'(start_FFT), 32'd1);
      do_frame("t3", 1'b0, 10, NFFT, 1, 1'b0, 2'b01);

      // No dv_FFT: timeout on ADC2, error stays sticky.
      frame_req = 2'b10;
      do_frame("t4", 1'b1, 0, 0, 0, 1'b1, 2'b10);
      repeat (3) step();
      check_val("t4_sticky", 32'(to_err), 32'd1);
      check_val("t4_idle",   32'(busy),   32'd0);

      // Short unload, then a normal frame is still serviced.
      apply_reset();
      frame_req = 2'b01;
      do_frame("t5", 1'b0, 5, 100, 0, 1'b1, 2'b01);
      frame_req = 2'b10;
      do_frame("t5b", 1'b1, 5, NFFT, 1, 1'b1, 2'b10);

      // Reset in the middle of LOAD, then a clean restart from address 0.
      apply_reset();
      frame_req = 2'b01;
      wait_start("t6");
      step();
      repeat (17) step();
      check_val("t6_addr17", 32'(xn_rd_addr), 32'd17);
      check_val("t6_rd_en",  32'(xn_rd_en),   32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("t6a");
      step();
      check_reset_vals("t6b");
      rst_n = 1'b1;
      do_frame("t6c", 1'b0, 3, NFFT, 1, 1'b0, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
